instr_sequencer: RTL

//   Multicycle fetch/decode/execute controller for the 8-bit processor datapath.

---
 rtl/proc_pkg.sv | 51 +++++
 rtl/instr_decoder.sv | 43 ++++
 rtl/instr_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Opcodes, FSM states and decode bundle for the 8-bit instruction sequencer.
// SINGLE_STEP_EN adds the STEP_WAIT state.
package proc_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_LDB = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_DWAIT,
`ifdef SINGLE_STEP_EN
    S_STEP,
`endif
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    JC_ALWAYS,
    JC_Z,
    JC_C
  } jcond_e;

  typedef struct packed {
    logic   uses_mem;
    logic   writes_a;
    logic   writes_b;
    logic   is_alu;
    logic   is_store;
    logic   is_jump;
    jcond_e jump_cond;
    logic   is_halt;
    logic   illegal;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: turns IR[7:4] into control flags.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    unique case (opcode_i)
      OP_NOP: ;
      OP_LDA: begin
        dec_o.uses_mem = 1'b1;
        dec_o.writes_a = 1'b1;
      end
      OP_STA: dec_o.is_store = 1'b1;
      OP_LDI: dec_o.writes_a = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_o.uses_mem = 1'b1;
        dec_o.writes_a = 1'b1;
        dec_o.is_alu   = 1'b1;
      end
      OP_JMP: dec_o.is_jump = 1'b1;
      OP_JZ: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = JC_Z;
      end
      OP_JC: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = JC_C;
      end
      OP_LDB: begin
        dec_o.uses_mem = 1'b1;
        dec_o.writes_b = 1'b1;
      end
      OP_HLT: dec_o.is_halt = 1'b1;
      4'hC, 4'hD, 4'hE: dec_o.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute controller between the RAM and the ULA.
// Optional SINGLE_STEP_EN: adds `step` input and a STEP_WAIT state.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int RESET_PC = 0,
  parameter  int MEM_LAT  = 1,
  localparam int ADDR_W   = DATA_W - 4
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] reg_a,
  output logic [ADDR_W-1:0] pc,
  output logic              z_flag,
  output logic              c_flag,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  dec_t              dec;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] new_a;
  logic              take;
  logic              b_unused;
  state_e            done_st;

  assign operand = ir_q[ADDR_W-1:0];
  assign new_a   = dec.is_alu ? alu_result : mem_rdata;
  assign b_unused = ^b_q;

`ifdef SINGLE_STEP_EN
  assign done_st = S_STEP;
`else
  assign done_st = S_FETCH;
`endif

  instr_decoder u_dec (
    .opcode_i (ir_q[DATA_W-1 -: 4]),
    .dec_o    (dec)
  );

  always_comb begin
    take = 1'b0;
    unique case (dec.jump_cond)
      JC_Z:    take = z_q;
      JC_C:    take = c_q;
      default: take = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    z_d        = z_q;
    c_d        = c_q;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        cnt_d    = '0;
        state_d  = S_FWAIT;
      end
      S_FWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d    = done_st;
        illegal_op = dec.illegal;
        if (dec.uses_mem) begin
          mem_rd   = 1'b1;
          mem_addr = operand;
          cnt_d    = '0;
          state_d  = S_DWAIT;
        end else if (dec.is_store) begin
          mem_we   = 1'b1;
          mem_addr = operand;
        end else if (dec.writes_a) begin
          a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
          z_d = (operand == '0);
        end else if (dec.is_jump) begin
          if (take) pc_d = operand;
        end else if (dec.is_halt) begin
          state_d = S_HALT;
        end
      end
      S_DWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST) begin
          state_d = done_st;
          if (dec.writes_b) begin
            b_d = mem_rdata;
          end else begin
            a_d = new_a;
            z_d = (new_a == '0);
            if (dec.is_alu) c_d = alu_carry;
          end
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
    // reset also kills strobes combinationally so a pending store never lands
    if (reset) begin
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC[ADDR_W-1:0];
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign mem_wdata  = a_q;
  assign alu_opcode = ir_q[DATA_W-1 -: 4];
  assign alu_a      = a_q;
  assign alu_b      = mem_rdata;
  assign reg_a      = a_q;
  assign pc         = pc_q;
  assign z_flag     = z_q;
  assign c_flag     = c_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);

endmodule
